// File: rtl/rs_mem.sv
// Memory reservation station: holds dispatched loads/stores, wakes sources on
// register broadcasts, issues the oldest ready entry and flushes on mispredict.
module rs_mem #(
  parameter int DEPTH  = 8,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [6:0]        disp_opcode,
  input  logic [PREG_W-1:0] disp_ps1,
  input  logic [PREG_W-1:0] disp_ps2,
  input  logic [PREG_W-1:0] disp_pd,
  input  logic              disp_ps1_rdy,
  input  logic              disp_ps2_rdy,
  input  logic [31:0]       disp_imm,
  input  logic [ROB_W-1:0]  disp_rob_tag,
  output logic              rs_full,
  input  logic              wk0_valid,
  input  logic [PREG_W-1:0] wk0_pd,
  input  logic              wk1_valid,
  input  logic [PREG_W-1:0] wk1_pd,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic              fu_mem_ready,
  output logic              issued,
  output logic [6:0]        iss_opcode,
  output logic [PREG_W-1:0] iss_ps1,
  output logic [PREG_W-1:0] iss_ps2,
  output logic [PREG_W-1:0] iss_pd,
  output logic [31:0]       iss_imm,
  output logic [ROB_W-1:0]  iss_rob_tag
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [6:0] OP_SW = 7'b0100011;

  // Handshakes: a dispatch is taken when disp_valid=1 and rs_full=0 (and no
  // flush); an issue happens when an entry is eligible and fu_mem_ready=1,
  // and is announced by issued=1 on the following cycle only.

  logic              e_valid  [DEPTH];
  logic [6:0]        e_opcode [DEPTH];
  logic [PREG_W-1:0] e_ps1    [DEPTH];
  logic [PREG_W-1:0] e_ps2    [DEPTH];
  logic [PREG_W-1:0] e_pd     [DEPTH];
  logic [31:0]       e_imm    [DEPTH];
  logic [ROB_W-1:0]  e_rob_tag[DEPTH];
  logic              e_rdy1   [DEPTH];
  logic              e_rdy2   [DEPTH];

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  flush_cnt;
  logic              issued_q;

  logic [ROB_W-1:0]  age [DEPTH];
  logic [ROB_W-1:0]  mp_age;
  logic [ROB_W-1:0]  iss_age;
  logic [DEPTH-1:0]  flush_vec;
  logic [DEPTH-1:0]  elig_vec;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [ROB_W-1:0]  sel_age;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_fire;
  logic              issue_fire;
  logic              disp_rdy1;
  logic              disp_rdy2;

  assign rs_full = (count == CNT_W'(DEPTH));

  // Ages are relative to the ROB head so ordering survives tag wrap-around.
  always_comb begin
    mp_age    = mispredict_tag - rob_head;
    iss_age   = iss_rob_tag - rob_head;
    flush_vec = '0;
    elig_vec  = '0;
    flush_cnt = '0;
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!e_valid[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      age[i]       = e_rob_tag[i] - rob_head;
      flush_vec[i] = mispredict && e_valid[i] && (age[i] > mp_age);
      elig_vec[i]  = e_valid[i] && !flush_vec[i] && e_rdy1[i] &&
                     (e_rdy2[i] || (e_opcode[i] != OP_SW));
      flush_cnt    = flush_cnt + CNT_W'(flush_vec[i]);
      if (elig_vec[i] && (!sel_found || (age[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  assign disp_fire  = disp_valid && !rs_full && !mispredict;
  assign issue_fire = fu_mem_ready && sel_found;
  assign count_next = count + CNT_W'(disp_fire) - CNT_W'(issue_fire) - flush_cnt;

  // Register 0 is hard-wired ready; same-cycle broadcasts also count.
  assign disp_rdy1 = disp_ps1_rdy || (disp_ps1 == '0) ||
                     (wk0_valid && (wk0_pd == disp_ps1)) ||
                     (wk1_valid && (wk1_pd == disp_ps1));
  assign disp_rdy2 = disp_ps2_rdy || (disp_ps2 == '0) ||
                     (wk0_valid && (wk0_pd == disp_ps2)) ||
                     (wk1_valid && (wk1_pd == disp_ps2));

  // A younger in-flight issue is squashed as soon as the flush is seen.
  assign issued = issued_q && !(mispredict && (iss_age > mp_age));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_valid[i]   <= 1'b0;
        e_opcode[i]  <= '0;
        e_ps1[i]     <= '0;
        e_ps2[i]     <= '0;
        e_pd[i]      <= '0;
        e_imm[i]     <= '0;
        e_rob_tag[i] <= '0;
        e_rdy1[i]    <= 1'b0;
        e_rdy2[i]    <= 1'b0;
      end
      count       <= '0;
      issued_q    <= 1'b0;
      iss_opcode  <= '0;
      iss_ps1     <= '0;
      iss_ps2     <= '0;
      iss_pd      <= '0;
      iss_imm     <= '0;
      iss_rob_tag <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i]) begin
          if ((wk0_valid && (wk0_pd == e_ps1[i])) || (wk1_valid && (wk1_pd == e_ps1[i])))
            e_rdy1[i] <= 1'b1;
          if ((wk0_valid && (wk0_pd == e_ps2[i])) || (wk1_valid && (wk1_pd == e_ps2[i])))
            e_rdy2[i] <= 1'b1;
        end
        if (flush_vec[i] || (issue_fire && (sel_idx == IDX_W'(i)))) begin
          e_valid[i] <= 1'b0;
        end else if (disp_fire && (free_idx == IDX_W'(i))) begin
          e_valid[i]   <= 1'b1;
          e_opcode[i]  <= disp_opcode;
          e_ps1[i]     <= disp_ps1;
          e_ps2[i]     <= disp_ps2;
          e_pd[i]      <= disp_pd;
          e_imm[i]     <= disp_imm;
          e_rob_tag[i] <= disp_rob_tag;
          e_rdy1[i]    <= disp_rdy1;
          e_rdy2[i]    <= disp_rdy2;
        end
      end
      count    <= count_next;
      issued_q <= issue_fire;
      if (issue_fire) begin
        iss_opcode  <= e_opcode[sel_idx];
        iss_ps1     <= e_ps1[sel_idx];
        iss_ps2     <= e_ps2[sel_idx];
        iss_pd      <= e_pd[sel_idx];
        iss_imm     <= e_imm[sel_idx];
        iss_rob_tag <= e_rob_tag[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_rs_mem.sv
// Bench for rs_mem: directed scenarios plus random traffic, all checked against
// a queue-based model that selects by ROB age.
module tb_rs_mem;
  localparam int DEPTH  = 8;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 7;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  logic              clk = 1'b0;
  logic              reset;
  logic              disp_valid;
  logic [6:0]        disp_opcode;
  logic [PREG_W-1:0] disp_ps1, disp_ps2, disp_pd;
  logic              disp_ps1_rdy, disp_ps2_rdy;
  logic [31:0]       disp_imm;
  logic [ROB_W-1:0]  disp_rob_tag;
  logic              rs_full;
  logic              wk0_valid, wk1_valid;
  logic [PREG_W-1:0] wk0_pd, wk1_pd;
  logic [ROB_W-1:0]  rob_head;
  logic              mispredict;
  logic [ROB_W-1:0]  mispredict_tag;
  logic              fu_mem_ready;
  logic              issued;
  logic [6:0]        iss_opcode;
  logic [PREG_W-1:0] iss_ps1, iss_ps2, iss_pd;
  logic [31:0]       iss_imm;
  logic [ROB_W-1:0]  iss_rob_tag;
  logic [64:0]       dut_pkt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rs_mem #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_pd(disp_pd),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_imm(disp_imm), .disp_rob_tag(disp_rob_tag), .rs_full(rs_full),
    .wk0_valid(wk0_valid), .wk0_pd(wk0_pd), .wk1_valid(wk1_valid), .wk1_pd(wk1_pd),
    .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .fu_mem_ready(fu_mem_ready), .issued(issued),
    .iss_opcode(iss_opcode), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
    .iss_imm(iss_imm), .iss_rob_tag(iss_rob_tag)
  );

  assign dut_pkt = {iss_opcode, iss_ps1, iss_ps2, iss_pd, iss_imm, iss_rob_tag};

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [6:0]  op;
    logic [6:0]  ps1, ps2, pd;
    logic [31:0] imm;
    logic [4:0]  tag;
    bit          r1, r2;
  } ent_t;

  ent_t        m_q[$];
  logic [64:0] exp_q[$];
  bit          m_iss_v;
  logic [64:0] m_last;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] pack(input ent_t e);
    return {e.op, e.ps1, e.ps2, e.pd, e.imm, e.tag};
  endfunction

  function automatic bit woke(input logic [6:0] p);
    return (wk0_valid && (wk0_pd == p)) || (wk1_valid && (wk1_pd == p));
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_iss_v = 1'b0;
    m_last  = '0;
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_step();
    int         sel;
    logic [4:0] best, a, mpa;
    bit         fl, ok, full;
    ent_t       e;
    ent_t       keep[$];
    if (!reset) begin
      model_reset();
      return;
    end
    mpa  = mispredict_tag - rob_head;
    full = (m_q.size() == DEPTH);
    sel  = -1;
    best = '0;
    foreach (m_q[i]) begin
      a  = m_q[i].tag - rob_head;
      fl = mispredict && (a > mpa);
      ok = m_q[i].r1 && ((m_q[i].op != OP_SW) || m_q[i].r2);
      if (!fl && ok && ((sel < 0) || (a < best))) begin
        sel  = i;
        best = a;
      end
    end
    m_iss_v = fu_mem_ready && (sel >= 0);
    if (m_iss_v) begin
      m_last = pack(m_q[sel]);
      exp_q.push_back(m_last);
    end
    foreach (m_q[i]) begin
      a  = m_q[i].tag - rob_head;
      fl = mispredict && (a > mpa);
      if (!fl && !(m_iss_v && (i == sel))) begin
        e = m_q[i];
        e.r1 = e.r1 || woke(e.ps1);
        e.r2 = e.r2 || woke(e.ps2);
        keep.push_back(e);
      end
    end
    if (disp_valid && !full && !mispredict) begin
      e.op  = disp_opcode;
      e.ps1 = disp_ps1;
      e.ps2 = disp_ps2;
      e.pd  = disp_pd;
      e.imm = disp_imm;
      e.tag = disp_rob_tag;
      e.r1  = disp_ps1_rdy || (disp_ps1 == 0) || woke(disp_ps1);
      e.r2  = disp_ps2_rdy || (disp_ps2 == 0) || woke(disp_ps2);
      keep.push_back(e);
    end
    m_q = keep;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [4:0]  mpa, ia;
    bit          exp_iss;
    logic [64:0] pkt;
    @(negedge clk);
    mpa     = mispredict_tag - rob_head;
    ia      = m_last[4:0] - rob_head;
    exp_iss = m_iss_v && !(mispredict && (ia > mpa));
    check("rs_full", rs_full, m_q.size() == DEPTH);
    check("issued", issued, exp_iss);
    if (m_iss_v) begin
      pkt = exp_q.pop_front();
      check("iss_pkt", dut_pkt, pkt);
    end else begin
      check("iss_hold", dut_pkt, m_last);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wk0_valid  = 1'b0;
    wk1_valid  = 1'b0;
    mispredict = 1'b0;
  endtask

  task automatic set_disp(input logic [6:0] op, input logic [4:0] tag,
                          input logic [6:0] p1, input bit r1,
                          input logic [6:0] p2, input bit r2, input logic [31:0] imm);
    disp_valid   = 1'b1;
    disp_opcode  = op;
    disp_rob_tag = tag;
    disp_ps1     = p1;
    disp_ps1_rdy = r1;
    disp_ps2     = p2;
    disp_ps2_rdy = r2;
    disp_pd      = {2'b10, tag};
    disp_imm     = imm;
  endtask

  task automatic drain(input int n);
    idle();
    fu_mem_ready = 1'b1;
    for (int k = 0; k < n; k++) cycle();
  endtask

  function automatic bit tag_used(input logic [4:0] t);
    foreach (m_q[i]) if (m_q[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] t;
    reset = 1'b1;
    idle();
    disp_opcode = OP_LW; disp_ps1 = '0; disp_ps2 = '0; disp_pd = '0;
    disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0; disp_imm = '0; disp_rob_tag = '0;
    wk0_pd = '0; wk1_pd = '0; rob_head = '0; mispredict_tag = '0; fu_mem_ready = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #2;
    check("rst_full", rs_full, 1'b0);
    check("rst_issued", issued, 1'b0);
    check("rst_iss", dut_pkt, 65'd0);
    cycle();
    cycle();
    reset = 1'b1;

    // LW ready at dispatch issues two cycles later
    fu_mem_ready = 1'b1;
    set_disp(OP_LW, 5'd3, 7'd10, 1'b1, 7'd0, 1'b0, 32'hABCD0123);
    cycle();
    idle();
    cycle();
    check("s1_issued", issued, 1'b1);
    check("s1_tag", iss_rob_tag, 5'd3);
    check("s1_imm", iss_imm, 32'hABCD0123);
    drain(3);

    // SW waits for ps2 wakeup on wk1
    set_disp(OP_SW, 5'd4, 7'd5, 1'b1, 7'd12, 1'b0, 32'h0000_0040);
    cycle();
    idle();
    cycle(); cycle(); cycle();
    wk1_valid = 1'b1; wk1_pd = 7'd12;
    cycle();
    idle();
    check("s2_no_early", issued, 1'b0);
    cycle();
    check("s2_issued", issued, 1'b1);
    check("s2_tag", iss_rob_tag, 5'd4);
    drain(3);

    // fill, drop when full, recover after one issue
    fu_mem_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      set_disp(OP_LW, 5'(8 + k), 7'd0, 1'b0, 7'd0, 1'b0, 32'(k));
      cycle();
    end
    check("s3_full", rs_full, 1'b1);
    set_disp(OP_LW, 5'd16, 7'd0, 1'b0, 7'd0, 1'b0, 32'hDEAD);
    cycle();
    idle();
    fu_mem_ready = 1'b1;
    cycle();
    fu_mem_ready = 1'b0;
    check("s3_not_full", rs_full, 1'b0);
    set_disp(OP_LW, 5'd17, 7'd0, 1'b0, 7'd0, 1'b0, 32'h17);
    cycle();
    idle();
    check("s3_refull", rs_full, 1'b1);
    drain(12);

    // age order across wrap
    rob_head = 5'd30;
    fu_mem_ready = 1'b0;
    set_disp(OP_LW, 5'd1, 7'd0, 1'b0, 7'd0, 1'b0, 32'h1);  cycle();
    set_disp(OP_LW, 5'd31, 7'd0, 1'b0, 7'd0, 1'b0, 32'h31); cycle();
    set_disp(OP_LW, 5'd30, 7'd0, 1'b0, 7'd0, 1'b0, 32'h30); cycle();
    idle();
    fu_mem_ready = 1'b1;
    cycle(); check("s4_first", iss_rob_tag, 5'd30);
    cycle(); check("s4_second", iss_rob_tag, 5'd31);
    cycle(); check("s4_third", iss_rob_tag, 5'd1);
    drain(2);

    // younger registered issue squashed combinationally; older one kept
    rob_head = 5'd0;
    set_disp(OP_LW, 5'd6, 7'd0, 1'b0, 7'd0, 1'b0, 32'h6);
    cycle();
    idle();
    cycle();
    mispredict = 1'b1; mispredict_tag = 5'd4;
    #1 check("kill_young", issued, 1'b0);
    cycle();
    idle();
    set_disp(OP_LW, 5'd3, 7'd0, 1'b0, 7'd0, 1'b0, 32'h3);
    cycle();
    idle();
    cycle();
    mispredict = 1'b1; mispredict_tag = 5'd5;
    #1 check("keep_old", issued, 1'b1);
    cycle();
    drain(2);

    // flush across wrap: only tag 29 survives
    rob_head = 5'd28;
    fu_mem_ready = 1'b0;
    set_disp(OP_LW, 5'd29, 7'd40, 1'b0, 7'd0, 1'b0, 32'h29); cycle();
    set_disp(OP_LW, 5'd31, 7'd40, 1'b0, 7'd0, 1'b0, 32'h31); cycle();
    set_disp(OP_LW, 5'd2,  7'd40, 1'b0, 7'd0, 1'b0, 32'h2);  cycle();
    idle();
    mispredict = 1'b1; mispredict_tag = 5'd30;
    cycle();
    idle();
    wk0_valid = 1'b1; wk0_pd = 7'd40;
    cycle();
    idle();
    fu_mem_ready = 1'b1;
    cycle();
    check("s5_survivor", iss_rob_tag, 5'd29);
    cycle();
    check("s5_only_one", issued, 1'b0);
    drain(2);

    // reset mid-operation with 5 valid entries
    rob_head = 5'd0;
    fu_mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_disp(OP_LW, 5'(20 + k), 7'd0, 1'b0, 7'd0, 1'b0, 32'(k));
      cycle();
    end
    idle();
    fu_mem_ready = 1'b1;
    cycle();
    fu_mem_ready = 1'b0;
    check("s6_pre_issued", issued, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    check("s6_rst_full", rs_full, 1'b0);
    check("s6_rst_issued", issued, 1'b0);
    check("s6_rst_iss", dut_pkt, 65'd0);
    cycle();
    cycle();
    reset = 1'b1;
    fu_mem_ready = 1'b1;
    set_disp(OP_LW, 5'd7, 7'd0, 1'b0, 7'd0, 1'b0, 32'h7);
    cycle();
    idle();
    cycle();
    check("s6_tag7", iss_rob_tag, 5'd7);
    drain(2);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        reset = 1'b0;
        model_reset();
        cycle();
        reset = 1'b1;
      end
      disp_valid   = ($urandom_range(0, 9) < 6);
      disp_opcode  = $urandom_range(0, 1) ? OP_SW : OP_LW;
      disp_ps1     = 7'($urandom_range(0, 7));
      disp_ps2     = 7'($urandom_range(0, 7));
      disp_pd      = 7'($urandom_range(0, 127));
      disp_ps1_rdy = ($urandom_range(0, 3) == 0);
      disp_ps2_rdy = ($urandom_range(0, 3) == 0);
      disp_imm     = $urandom;
      t = 5'($urandom_range(0, 31));
      while (tag_used(t)) t = t + 5'd1;
      disp_rob_tag = t;
      wk0_valid    = ($urandom_range(0, 9) < 4);
      wk0_pd       = 7'($urandom_range(0, 7));
      wk1_valid    = ($urandom_range(0, 9) < 4);
      wk1_pd       = 7'($urandom_range(0, 7));
      fu_mem_ready = ($urandom_range(0, 9) < 7);
      mispredict   = ($urandom_range(0, 19) == 0);
      mispredict_tag = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rob_head = 5'($urandom_range(0, 31));
      cycle();
    end
    drain(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_mem.md
RS_MEM -- requirements
Module: rs_mem

Interface
REQ-001 Parameter DEPTH, default 8: number of reservation-station entries, power of two.
REQ-002 Parameter ROB_W, default 5: ROB tag width (32-entry ROB).
REQ-003 Parameter PREG_W, default 7: physical register index width.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; state clears while reset=0.
- disp_valid  in  1  dispatch a load or store this cycle.
- disp_opcode  in  7  0000011 = LW, 0100011 = SW.
- disp_ps1, disp_ps2, disp_pd  in  PREG_W each  source and destination physical registers.
- disp_ps1_rdy, disp_ps2_rdy  in  1 each  source ready at dispatch.
- disp_imm  in  32  sign-extended immediate.
- disp_rob_tag  in  ROB_W  ROB index of the instruction.
- rs_full  out  1  no free entry.
- wk0_valid, wk1_valid  in  1 each  wakeup broadcast valid.
- wk0_pd, wk1_pd  in  PREG_W each  wakeup register tags.
- rob_head  in  ROB_W  oldest in-flight ROB tag.
- mispredict  in  1  flush request.
- mispredict_tag  in  ROB_W  ROB tag of the mispredicting branch.
- fu_mem_ready  in  1  downstream memory unit accepts an issue.
- issued  out  1  issue strobe to the memory unit.
- iss_opcode 7, iss_ps1 PREG_W, iss_ps2 PREG_W, iss_pd PREG_W, iss_imm 32, iss_rob_tag ROB_W  out  issued instruction fields.

Function
REQ-006 Each entry SHALL hold valid, opcode, ps1, ps2, pd, imm, rob_tag, rdy1 and rdy2.
REQ-007 Physical register 0 SHALL be treated as always ready.
REQ-008 rs_full SHALL equal 1 when the valid-entry count (log2(DEPTH)+1 bits) equals DEPTH; it is computed from the registered count only, with no bypass of a same-cycle issue.
REQ-009 Dispatch SHALL write the lowest-index free entry when disp_valid=1 and rs_full=0; when rs_full=1 the dispatch SHALL be dropped with no state change.
REQ-010 Dispatch source ready SHALL be the OR of disp_psN_rdy, a wk0 match and a wk1 match in the same cycle.
REQ-011 Each wakeup port SHALL set rdyN in every valid entry whose psN equals wkX_pd.
REQ-012 Eligibility: an LW requires rdy1; an SW requires rdy1 and rdy2. Eligibility SHALL be evaluated from registered ready bits, so a same-cycle wakeup is not visible until the next cycle.
REQ-013 Age SHALL be (rob_tag - rob_head) mod 2^ROB_W.
REQ-014 Selection SHALL pick the eligible entry with the smallest age; ties are impossible because tags are unique.
REQ-015 When fu_mem_ready=1 and an eligible entry exists, the selected entry SHALL be freed at the clock edge and its fields registered onto the iss_* outputs, with issued=1 for exactly the following cycle.
REQ-016 When no issue occurs, issued SHALL be 0 and the iss_* outputs SHALL hold their last values.
REQ-017 Issue latency SHALL be 1 cycle from a select cycle to issued=1; dispatch-to-earliest-issue latency SHALL be 2 cycles.
REQ-018 At most one dispatch and one issue SHALL occur per cycle, and both may occur together.
REQ-019 On mispredict=1, every valid entry whose age is greater than age(mispredict_tag) SHALL be invalidated at that edge.
REQ-020 On mispredict=1, a same-cycle dispatch SHALL be dropped, and flushed entries SHALL be excluded from selection that cycle.
REQ-021 On mispredict=1, a registered issued=1 whose iss_rob_tag is younger than mispredict_tag SHALL be cleared to 0 combinationally.
REQ-022 Entries with age less than or equal to age(mispredict_tag) SHALL survive a flush, including across ROB tag wrap-around (tag 31 followed by tag 0).
REQ-023 Count SHALL update as count + dispatch - issue - flushed each cycle and SHALL never exceed DEPTH or underflow.

Reset
REQ-024 While reset=0, all entry valid bits, count, issued and the iss_* outputs SHALL be 0, and rs_full SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately, and the first dispatch after reset release SHALL land in entry 0.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- LW tag 3, ps1=10 ready, fu_mem_ready=1 -> issued=1 two cycles after dispatch with iss_rob_tag=3 and iss_imm echoed.
- SW ps2=12 not ready; wk1_pd=12 pulses at cycle 4 -> no issue at cycle 4; issued=1 at cycle 6.
- Fill 8 entries -> rs_full=1; a 9th dispatch is dropped; after one issue, rs_full=0 and the next dispatch is accepted.
- rob_head=30, ready entries with tags 1, 31, 30 -> issue order 30, 31, 1.
- rob_head=28, entries with tags 29, 31, 2, mispredict_tag=30 -> tags 31 and 2 invalidated, tag 29 survives, count=1.
- reset=0 with 5 valid entries -> rs_full=0, issued=0 immediately; after release, tag 7 is dispatched into entry 0.
